// File: rtl/cmd_result_gen.sv
// Voice-command result generator: collects classified frames and issues one recognition verdict per attempt.
// Latency: the verdict pulse appears one cycle after the deciding frame or the timeout; o_idle and the pulse are both registered.
// No backpressure: o_cmd_valid is a fire-and-forget pulse, and inputs arriving outside COLLECT (or IDLE for start) are dropped.
module cmd_result_gen #(
   parameter int unsigned N_FRAMES  = 8,
   parameter int unsigned THRESHOLD = 5,
   parameter int unsigned TIMEOUT   = 1000,
   parameter int unsigned HOLDOFF   = 100
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_init_done,
   input  logic       i_start,
   input  logic       i_frame_valid,
   input  logic       i_frame_match,
   input  logic       i_abort,
   output logic       o_idle,
   output logic       o_cmd_valid,
   output logic       o_cmd_recon,
   output logic [7:0] o_match_count
);

   typedef enum logic [2:0] {
      ST_WAIT_INIT,
      ST_IDLE,
      ST_COLLECT,
      ST_REPORT,
      ST_HOLDOFF
   } state_t;

   localparam logic [7:0]  N_LAST  = 8'(N_FRAMES);
   localparam logic [7:0]  THRESH  = 8'(THRESHOLD);
   // The timeout fires on the cycle the counter would reach TIMEOUT-1, so the
   // verdict lands exactly TIMEOUT cycles after the last frame (or the start).
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 2);
   localparam logic [15:0] HO_LAST = 16'(HOLDOFF - 1);

   state_t      state_q, state_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic [7:0]  match_cnt_q, match_cnt_d;
   // Shared cycle counter: inter-frame timeout in COLLECT, dwell time in HOLDOFF.
   logic [15:0] cyc_cnt_q, cyc_cnt_d;
   logic        recon_d;
   logic        idle_q, valid_q, recon_q;

   // Next-state and counter logic; loss of init_done overrides everything.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      match_cnt_d = match_cnt_q;
      cyc_cnt_d   = cyc_cnt_q;
      recon_d     = 1'b0;
      if (!i_init_done) begin
         state_d = ST_WAIT_INIT;
      end else begin
         case (state_q)
            ST_WAIT_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
               // A frame arriving with start is not counted.
               if (i_start) begin
                  state_d     = ST_COLLECT;
                  frame_cnt_d = '0;
                  match_cnt_d = '0;
                  cyc_cnt_d   = '0;
               end
            end
            ST_COLLECT: begin
               if (i_abort) begin
                  state_d = ST_IDLE;
               end else if (i_frame_valid) begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
                  match_cnt_d = match_cnt_q + {7'd0, i_frame_match};
                  cyc_cnt_d   = '0;
                  if (frame_cnt_d == N_LAST) begin
                     state_d = ST_REPORT;
                     recon_d = (match_cnt_d >= THRESH);
                  end
               end else if (cyc_cnt_q == TO_LAST) begin
                  state_d = ST_REPORT;
                  recon_d = (match_cnt_q >= THRESH);
               end else begin
                  cyc_cnt_d = cyc_cnt_q + 16'd1;
               end
            end
            ST_REPORT: begin
               state_d   = ST_HOLDOFF;
               cyc_cnt_d = '0;
            end
            ST_HOLDOFF: begin
               if (cyc_cnt_q == HO_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  cyc_cnt_d = cyc_cnt_q + 16'd1;
               end
            end
            default: state_d = ST_WAIT_INIT;
         endcase
      end
   end

   // State, counters and registered outputs; outputs track the next state so
   // they coincide with the state they describe.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= ST_WAIT_INIT;
         frame_cnt_q <= '0;
         match_cnt_q <= '0;
         cyc_cnt_q   <= '0;
         idle_q      <= 1'b0;
         valid_q     <= 1'b0;
         recon_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         match_cnt_q <= match_cnt_d;
         cyc_cnt_q   <= cyc_cnt_d;
         idle_q      <= (state_d == ST_IDLE);
         valid_q     <= (state_d == ST_REPORT);
         recon_q     <= recon_d;
      end
   end

   assign o_idle        = idle_q;
   assign o_cmd_valid   = valid_q;
   assign o_cmd_recon   = recon_q;
   assign o_match_count = match_cnt_q;

endmodule

// File: tb/tb_cmd_result_gen.sv
// Scoreboard bench for cmd_result_gen: stimulus pushes expected verdicts, a negedge monitor pops and compares them.
// Latency is checked by pushing the expected pulse cycle alongside recon and match count.
// The DUT exerts no backpressure; unexpected pulses are reported as failures.
module tb_cmd_result_gen;

   localparam int N_FRAMES  = 8;
   localparam int THRESHOLD = 5;
   localparam int TIMEOUT   = 16;
   localparam int HOLDOFF   = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_init_done, i_start, i_frame_valid, i_frame_match, i_abort;
   logic       o_idle, o_cmd_valid, o_cmd_recon;
   logic [7:0] o_match_count;

   typedef struct {
      bit recon;
      int cnt;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   gaps[$];
   bit   mts[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   cmd_result_gen #(
      .N_FRAMES(N_FRAMES), .THRESHOLD(THRESHOLD), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)
   ) dut (
      .i_clock(clk),
      .i_reset(rst_n),
      .i_init_done(i_init_done),
      .i_start(i_start),
      .i_frame_valid(i_frame_valid),
      .i_frame_match(i_frame_match),
      .i_abort(i_abort),
      .o_idle(o_idle),
      .o_cmd_valid(o_cmd_valid),
      .o_cmd_recon(o_cmd_recon),
      .o_match_count(o_match_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Advance one cycle; pulse inputs fall back to 0, init_done is left alone.
   task automatic step();
      @(posedge clk);
      #1;
      i_start       = 1'b0;
      i_frame_valid = 1'b0;
      i_frame_match = 1'b0;
      i_abort       = 1'b0;
   endtask

   // Reference model of one attempt: frames at the given gaps (cycles after the
   // previous event), a gap of TIMEOUT or more means the attempt times out,
   // the N_FRAMES-th frame ends it, an abort frame cancels it.
   task automatic run_attempt(input int abort_idx);
      int   last, n, m, p, w, g;
      bit   done, aborted;
      exp_t e;
      w = 0;
      while (!o_idle && w < 50) begin
         step();
         w++;
      end
      chk("idle_before_start", int'(o_idle), 1);
      i_start = 1'b1;
      last = cyc; n = 0; m = 0; p = 0; done = 0; aborted = 0;
      foreach (gaps[i]) begin
         g = gaps[i];
         if (g >= TIMEOUT) break;
         repeat (g) step();
         i_frame_valid = 1'b1;
         i_frame_match = mts[i];
         if (i == abort_idx) begin
            i_abort = 1'b1;
            aborted = 1;
            break;
         end
         n++;
         m += int'(mts[i]);
         last = cyc;
         if (n == N_FRAMES) begin
            done = 1;
            p = cyc + 1;
            break;
         end
      end
      if (aborted) begin
         step();
         chk("idle_after_abort", int'(o_idle), 1);
      end else begin
         if (!done) p = last + TIMEOUT;
         e.recon = (m >= THRESHOLD);
         e.cnt   = m;
         e.cyc   = p;
         exp_q.push_back(e);
         while (cyc < p + HOLDOFF) begin
            step();
            if (cyc >= p) begin
               i_start       = 1'($urandom_range(0, 1));
               i_frame_valid = 1'($urandom_range(0, 1));
               i_frame_match = 1'($urandom_range(0, 1));
               i_abort       = 1'($urandom_range(0, 1));
            end
         end
         chk("idle_in_holdoff", int'(o_idle), 0);
         step();
         chk("idle_after_holdoff", int'(o_idle), 1);
         chk("count_held", int'(o_match_count), m);
      end
   endtask

   task automatic set_frames(input int nfr, input int gap, input bit [7:0] pat);
      gaps.delete();
      mts.delete();
      for (int i = 0; i < nfr; i++) begin
         gaps.push_back(gap);
         mts.push_back(pat[7-i]);
      end
   endtask

   // Monitor: every verdict pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (o_cmd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got o_cmd_valid=1 at cycle %0d, required no pulse", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("recon", int'(o_cmd_recon), int'(mon_e.recon));
            chk("match_count", int'(o_match_count), mon_e.cnt);
            chk("pulse_cycle", cyc, mon_e.cyc);
         end
      end else begin
         chk("recon_low_without_valid", int'(o_cmd_recon), 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nfr, ab;
      rst_n = 1'b0;
      i_init_done = 1'b0; i_start = 1'b0; i_frame_valid = 1'b0;
      i_frame_match = 1'b0; i_abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_idle", int'(o_idle), 0);
      chk("rst_valid", int'(o_cmd_valid), 0);
      chk("rst_recon", int'(o_cmd_recon), 0);
      chk("rst_count", int'(o_match_count), 0);
      rst_n = 1'b1;
      step(); step();
      chk("wait_init_not_idle", int'(o_idle), 0);
      i_init_done = 1'b1;
      step();
      chk("idle_after_init", int'(o_idle), 1);

      // 8 frames, 5 matches: recognised.
      set_frames(8, 1, 8'b1101_1010);
      run_attempt(-1);
      // 8 frames, 4 matches, spread out: not recognised.
      set_frames(8, 3, 8'b1010_1010);
      run_attempt(-1);
      // 3 frames then silence: timeout with 3 counted.
      set_frames(3, 2, 8'b1110_0000);
      run_attempt(-1);
      // Gaps of TIMEOUT-1 still accepted, then a TIMEOUT gap expires.
      set_frames(4, 15, 8'b1111_0000);
      gaps[3] = 16;
      run_attempt(-1);
      // Start with no frames at all.
      set_frames(0, 1, 8'h00);
      run_attempt(-1);
      // Abort coincident with the third frame.
      set_frames(3, 1, 8'b1110_0000);
      run_attempt(2);

      // Reset mid-COLLECT after 6 frames.
      step();
      i_start = 1'b1;
      repeat (6) begin
         step();
         i_frame_valid = 1'b1;
         i_frame_match = 1'b1;
      end
      step();
      chk("count_before_reset", int'(o_match_count), 6);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_idle", int'(o_idle), 0);
      chk("async_rst_valid", int'(o_cmd_valid), 0);
      chk("async_rst_recon", int'(o_cmd_recon), 0);
      chk("async_rst_count", int'(o_match_count), 0);
      step(); step();
      rst_n = 1'b1;
      step(); step();
      chk("idle_after_reset_release", int'(o_idle), 1);
      repeat (TIMEOUT + 4) step();

      // init_done drop mid-COLLECT: back to WAIT_INIT, no verdict.
      i_start = 1'b1;
      repeat (3) begin
         step();
         i_frame_valid = 1'b1;
         i_frame_match = 1'b1;
      end
      step();
      i_init_done = 1'b0;
      step();
      chk("idle_after_init_drop", int'(o_idle), 0);
      repeat (TIMEOUT + 4) step();
      chk("still_waiting_init", int'(o_idle), 0);
      i_init_done = 1'b1;
      step();
      chk("idle_after_init_return", int'(o_idle), 1);

      // Randomised attempts.
      for (int t = 0; t < 30; t++) begin
         nfr = $urandom_range(0, 10);
         gaps.delete();
         mts.delete();
         for (int i = 0; i < nfr; i++) begin
            gaps.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(10, 20)
                                                       : $urandom_range(1, 3));
            mts.push_back(1'($urandom_range(0, 1)));
         end
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1;
         run_attempt(ab);
      end

      repeat (5) step();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
